// File: rtl/pcie_msi_pkg.sv
// rtl/pcie_msi_pkg.sv - shared types and helpers for the MSI/INTx interrupt arbiter
package pcie_msi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } msi_state_e;

    localparam int MSI_NUM_W = 5;
    localparam int MAX_CH    = 32;

    // Host allocates 2^mme vectors, capped at 32; the mask folds a channel onto them.
    function automatic logic [MSI_NUM_W-1:0] mme_fold_mask(input logic [2:0] mme);
        logic [2:0] e;
        e = (mme > 3'd5) ? 3'd5 : mme;
        return MSI_NUM_W'((6'd1 << e) - 6'd1);
    endfunction

endpackage

// File: rtl/pcie_msi_arbiter_if.sv
// rtl/pcie_msi_arbiter_if.sv - HIP int_msi port group between arbiter and PCIe hard IP
interface pcie_msi_arbiter_if;
    import pcie_msi_pkg::*;

    logic                 app_msi_req;
    logic [MSI_NUM_W-1:0] app_msi_num;
    logic [2:0]           app_msi_tc;
    logic                 app_msi_ack;
    logic                 app_int_sts;

    modport master (
        output app_msi_req,
        output app_msi_num,
        output app_msi_tc,
        output app_int_sts,
        input  app_msi_ack
    );

    modport slave (
        input  app_msi_req,
        input  app_msi_num,
        input  app_msi_tc,
        input  app_int_sts,
        output app_msi_ack
    );

endinterface

// File: rtl/pcie_rr_arb.sv
// rtl/pcie_rr_arb.sv - combinational round-robin find-first starting after ptr
module pcie_rr_arb #(
    parameter  int N_CH  = 8,
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan from the farthest candidate back to ptr+1 so the nearest hit wins last.
    always_comb begin
        int c;
        idx   = '0;
        valid = 1'b0;
        c     = 0;
        for (int i = N_CH; i >= 1; i--) begin
            c = (int'(ptr) + i) % N_CH;
            if (req[IDX_W'(c)]) begin
                idx   = IDX_W'(c);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcie_msi_arbiter.sv
// rtl/pcie_msi_arbiter.sv - round-robin MSI arbiter with INTx fallback for the PCIe HIP
module pcie_msi_arbiter
    import pcie_msi_pkg::*;
#(
    parameter int         N_CH        = 8,
    parameter logic [2:0] MSI_TC      = 3'd0,
    parameter int         ACK_TIMEOUT = 1023
) (
    input  logic                pld_clk_clk,
    input  logic                reset_n,
    input  logic [N_CH-1:0]     irq_pulse,
    input  logic [N_CH-1:0]     irq_mask,
    input  logic [N_CH-1:0]     irq_clr,
    input  logic                msi_enable,
    input  logic [2:0]          msi_mme,
    pcie_msi_arbiter_if.master  hip,
    output logic [N_CH-1:0]     irq_pending,
    output logic [N_CH-1:0]     irq_overflow,
    output logic                msi_timeout
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    msi_state_e           state, state_n;
    logic [N_CH-1:0]      pending, overflow, eligible, ack_clr;
    logic [IDX_W-1:0]     ptr, grant_ch, arb_idx;
    logic                 arb_valid, ack_hit, to_hit, grant;
    logic [MSI_NUM_W-1:0] num_q, ch_ext;
    logic [CNT_W-1:0]     cnt;
    logic                 timeout_q, int_sts_q;

    pcie_rr_arb #(.N_CH(N_CH)) u_arb (
        .req   (eligible),
        .ptr   (ptr),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_comb begin
        eligible = pending & irq_mask;
        ack_hit  = (state == ST_REQ) && hip.app_msi_ack;
        // cnt holds the number of completed REQ cycles, so hitting LAST ends the ACK_TIMEOUT-th one
        to_hit   = (ACK_TIMEOUT != 0) && (state == ST_REQ) && !hip.app_msi_ack && (cnt == CNT_LAST);
        grant    = msi_enable && arb_valid;
        ack_clr  = '0;
        if (ack_hit) begin
            ack_clr[grant_ch] = 1'b1;
        end
        ch_ext = '0;
        ch_ext[IDX_W-1:0] = arb_idx;
    end

    always_ff @(posedge pld_clk_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (grant) state_n = ST_REQ;
            ST_REQ:  if (ack_hit || to_hit) state_n = ST_GAP;
            ST_GAP:  state_n = grant ? ST_REQ : ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        hip.app_msi_req = (state == ST_REQ);
        hip.app_msi_num = num_q;
        hip.app_msi_tc  = MSI_TC;
        hip.app_int_sts = int_sts_q;
        irq_pending     = pending;
        irq_overflow    = overflow;
        msi_timeout     = timeout_q;
    end

    always_ff @(posedge pld_clk_clk or negedge reset_n) begin
        if (!reset_n) begin
            pending   <= '0;
            overflow  <= '0;
            ptr       <= '0;
            grant_ch  <= '0;
            num_q     <= '0;
            cnt       <= '0;
            timeout_q <= 1'b0;
            int_sts_q <= 1'b0;
        end else begin
            // A new event always survives a same-cycle clear or ack.
            pending   <= irq_pulse | (pending & ~irq_clr & ~ack_clr);
            overflow  <= (overflow & ~irq_clr) | (irq_pulse & pending);
            int_sts_q <= !msi_enable && (|eligible);
            cnt       <= (state == ST_REQ) ? cnt + 1'b1 : '0;
            if (ack_hit) begin
                ptr <= grant_ch;
            end
            if (to_hit) begin
                timeout_q <= 1'b1;
            end
            if ((state != ST_REQ) && grant) begin
                grant_ch <= arb_idx;
                num_q    <= ch_ext & mme_fold_mask(msi_mme);
            end
        end
    end

endmodule

// File: tb/tb_pcie_msi_arbiter.sv
// tb/tb_pcie_msi_arbiter.sv - self-checking bench for pcie_msi_arbiter
module tb_pcie_msi_arbiter;
    import pcie_msi_pkg::*;

    localparam int         N  = 8;
    localparam int         TO = 16;
    localparam logic [2:0] TC = 3'd5;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   pulse, mask, clr;
    logic           en;
    logic [2:0]     mme;
    logic [N-1:0]   pend, ovf;
    logic           tmo;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pcie_msi_arbiter_if hip ();

    pcie_msi_arbiter #(.N_CH(N), .MSI_TC(TC), .ACK_TIMEOUT(TO)) dut (
        .pld_clk_clk  (clk),
        .reset_n      (rst_n),
        .irq_pulse    (pulse),
        .irq_mask     (mask),
        .irq_clr      (clr),
        .msi_enable   (en),
        .msi_mme      (mme),
        .hip          (hip),
        .irq_pending  (pend),
        .irq_overflow (ovf),
        .msi_timeout  (tmo)
    );

    // Reference model: an outstanding-request record plus pending/overflow sets.
    logic [N-1:0] m_pend, m_ovf;
    bit           m_busy, m_to, m_sts;
    int           m_ch, m_ptr, m_age, m_num;

    task automatic model_reset();
        m_pend = '0; m_ovf = '0;
        m_busy = 0; m_to = 0; m_sts = 0;
        m_ch = 0; m_ptr = 0; m_age = 0; m_num = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] elig, acked;
        bit           new_sts;
        elig    = m_pend & mask;
        acked   = '0;
        new_sts = !en && (elig != 0);
        if (m_busy) begin
            if (hip.app_msi_ack) begin
                acked[m_ch] = 1'b1;
                m_ptr  = m_ch;
                m_busy = 0;
            end else begin
                m_age++;
                if (m_age == TO) begin
                    m_busy = 0;
                    m_to   = 1;
                end
            end
        end else if (en && elig != 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (elig[c]) begin
                    m_ch = c;
                    break;
                end
            end
            m_num  = m_ch % (1 << ((mme > 5) ? 5 : int'(mme)));
            m_busy = 1;
            m_age  = 0;
        end
        m_ovf  = (m_ovf & ~clr) | (pulse & m_pend);
        m_pend = pulse | (m_pend & ~clr & ~acked);
        m_sts  = new_sts;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("req",      32'(hip.app_msi_req), 32'(m_busy));
        chk("num",      32'(hip.app_msi_num), 32'(m_num));
        chk("tc",       32'(hip.app_msi_tc),  32'(TC));
        chk("int_sts",  32'(hip.app_int_sts), 32'(m_sts));
        chk("pending",  32'(pend),            32'(m_pend));
        chk("overflow", 32'(ovf),             32'(m_ovf));
        chk("timeout",  32'(tmo),             32'(m_to));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        pulse = '0;
        clr   = '0;
        hip.app_msi_ack = 1'b0;
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        pulse = '0; clr = '0; hip.app_msi_ack = 1'b0;
        #2;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();
    endtask

    task automatic ack_now();
        hip.app_msi_ack = 1'b1;
        cycle();
    endtask

    initial begin
        int n;
        int order [3] = '{1, 3, 6};
        pulse = '0; clr = '0; mask = '1; en = 1'b1; mme = 3'd3;
        hip.app_msi_ack = 1'b0;
        model_reset();
        do_reset();
        chk("reset_tc", 32'(hip.app_msi_tc), 32'(3'd5));
        chk("reset_req", 32'(hip.app_msi_req), 32'd0);

        // Single event, latency and ack
        pulse = 8'h20; cycle();
        chk("t1_pend", 32'(pend), 32'h20);
        chk("t1_req_early", 32'(hip.app_msi_req), 32'd0);
        cycle();
        chk("t1_req", 32'(hip.app_msi_req), 32'd1);
        chk("t1_num", 32'(hip.app_msi_num), 32'd5);
        cycle(); cycle(); cycle();
        chk("t1_req_hold", 32'(hip.app_msi_req), 32'd1);
        ack_now();
        chk("t1_req_drop", 32'(hip.app_msi_req), 32'd0);
        chk("t1_pend_clr", 32'(pend), 32'h00);
        cycle();
        chk("t1_idle", 32'(hip.app_msi_req), 32'd0);

        // Round-robin order from ptr=0 with single-cycle gaps
        do_reset();
        pulse = 8'h4A; cycle(); cycle();
        for (int i = 0; i < 3; i++) begin
            chk("t2_req", 32'(hip.app_msi_req), 32'd1);
            chk("t2_order", 32'(hip.app_msi_num), 32'(order[i]));
            ack_now();
            chk("t2_gap", 32'(hip.app_msi_req), 32'd0);
            if (i < 2) cycle();
        end
        cycle();
        chk("t2_done", 32'(pend), 32'h00);

        // Vector folding
        mme = 3'd1; pulse = 8'h40; cycle(); cycle();
        chk("t3_req_m1", 32'(hip.app_msi_req), 32'd1);
        chk("t3_num_m1", 32'(hip.app_msi_num), 32'd0);
        ack_now();
        mme = 3'd2; pulse = 8'h40; cycle(); cycle();
        chk("t3_num_m2", 32'(hip.app_msi_num), 32'd2);
        ack_now();

        // Set wins over ack clear, overflow is sticky until irq_clr
        mme = 3'd3; pulse = 8'h04; cycle(); cycle();
        chk("t4_num", 32'(hip.app_msi_num), 32'd2);
        pulse = 8'h04; ack_now();
        chk("t4_pend_kept", 32'(pend[2]), 32'd1);
        chk("t4_ovf", 32'(ovf[2]), 32'd1);
        cycle();
        chk("t4_req_again", 32'(hip.app_msi_req), 32'd1);
        chk("t4_num_again", 32'(hip.app_msi_num), 32'd2);
        ack_now();
        chk("t4_pend_clr", 32'(pend), 32'h00);
        chk("t4_ovf_sticky", 32'(ovf[2]), 32'd1);
        clr = 8'h04; cycle();
        chk("t4_ovf_clr", 32'(ovf), 32'h00);

        // Ack timeout
        pulse = 8'h01; cycle(); cycle();
        n = 0;
        while (hip.app_msi_req && n < 40) begin
            n++;
            cycle();
        end
        chk("t5_req_len", 32'(n), 32'd16);
        chk("t5_timeout", 32'(tmo), 32'd1);
        chk("t5_pend_kept", 32'(pend[0]), 32'd1);
        cycle();
        chk("t5_reraise", 32'(hip.app_msi_req), 32'd1);
        ack_now();
        chk("t5_sticky", 32'(tmo), 32'd1);
        do_reset();
        chk("t5_reset", 32'(tmo), 32'd0);

        // Legacy INTx fallback
        en = 1'b0; mask = 8'hEF; pulse = 8'h10; cycle(); cycle();
        chk("t6_masked", 32'(hip.app_int_sts), 32'd0);
        chk("t6_pend", 32'(pend), 32'h10);
        mask = 8'hFF; cycle();
        chk("t6_unmask", 32'(hip.app_int_sts), 32'd1);
        cycle();
        chk("t6_no_req", 32'(hip.app_msi_req), 32'd0);
        clr = 8'h10; cycle();
        chk("t6_clr_pend", 32'(pend), 32'h00);
        cycle();
        chk("t6_sts_low", 32'(hip.app_int_sts), 32'd0);

        // Randomised traffic against the model
        en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            pulse = ($urandom_range(0, 3) == 0) ? (N'($urandom) & N'($urandom)) : '0;
            clr   = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 31) == 0) mask = N'($urandom);
            if ($urandom_range(0, 63) == 0) en = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 31) == 0) mme = 3'($urandom);
            if (hip.app_msi_req)
                hip.app_msi_ack = ($urandom_range(0, 2) == 0);
            else
                hip.app_msi_ack = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
